// File: rtl/yv12_chroma_upsampler_pkg.sv
// rtl/yv12_chroma_upsampler_pkg.sv - shared geometry constants and row phase type
package yv12_pkg;

  localparam int IMG_WIDTH    = 320;
  localparam int IMG_HEIGHT   = 466;
  localparam int COORD_W      = 10;
  localparam int CHROMA_DEPTH = IMG_WIDTH / 2;

  typedef enum logic {
    FILL   = 1'b0,
    REPLAY = 1'b1
  } phase_e;

endpackage

// File: rtl/yv12_chroma_upsampler_if.sv
// rtl/yv12_chroma_upsampler_if.sv - luma/chroma input streams and upsampled pixel output
interface yv12_chroma_upsampler_if #(
  parameter int COORD_W = yv12_pkg::COORD_W
);

  logic               y_valid;
  logic [7:0]         y_in;
  logic               y_ready;
  logic               c_valid;
  logic [7:0]         u_in;
  logic [7:0]         v_in;
  logic               c_ready;
  logic               data_valid;
  logic [7:0]         y_data;
  logic [7:0]         u_data;
  logic [7:0]         v_data;
  logic [COORD_W-1:0] pixel_x;
  logic [COORD_W-1:0] pixel_y;
  logic               sof;
  logic               eol;

  modport slave (
    input  y_valid, y_in, c_valid, u_in, v_in,
    output y_ready, c_ready, data_valid, y_data, u_data, v_data,
           pixel_x, pixel_y, sof, eol
  );

  modport master (
    output y_valid, y_in, c_valid, u_in, v_in,
    input  y_ready, c_ready, data_valid, y_data, u_data, v_data,
           pixel_x, pixel_y, sof, eol
  );

endinterface

// File: rtl/yv12_chroma_linebuf.sv
// rtl/yv12_chroma_linebuf.sv - half-width chroma pair store, sync write, async read
module yv12_chroma_linebuf
  import yv12_pkg::*;
#(
  parameter int DEPTH = CHROMA_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [15:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [15:0]   rdata
);

  logic [15:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/yv12_chroma_upsampler.sv
// rtl/yv12_chroma_upsampler.sv - merges 4:2:0 chroma pairs with luma into one YUV pixel per clock
module yv12_chroma_upsampler
  import yv12_pkg::*;
#(
  parameter int IMG_WIDTH  = yv12_pkg::IMG_WIDTH,
  parameter int IMG_HEIGHT = yv12_pkg::IMG_HEIGHT,
  parameter int COORD_W    = yv12_pkg::COORD_W
) (
  input  logic                     clk,
  input  logic                     rst,
  yv12_chroma_upsampler_if.slave   bus
);

  localparam int LB_DEPTH = IMG_WIDTH / 2;
  localparam int LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

  if ((IMG_WIDTH % 2) != 0) begin : g_bad_width
    $error("IMG_WIDTH must be even");
  end
  if ((IMG_HEIGHT % 2) != 0) begin : g_bad_height
    $error("IMG_HEIGHT must be even");
  end

  logic [COORD_W-1:0] x_q;
  logic [COORD_W-1:0] y_q;
  phase_e             phase_q;
  logic [15:0]        hold_q;

  logic               need_c;
  logic               fire;
  logic               x_last;
  logic               y_last;
  logic [LB_AW-1:0]   lb_addr;
  logic [15:0]        lb_rdata;
  logic [15:0]        pair_in;
  logic [15:0]        chroma;

  logic               data_valid_q;
  logic [7:0]         y_data_q;
  logic [7:0]         u_data_q;
  logic [7:0]         v_data_q;
  logic [COORD_W-1:0] pixel_x_q;
  logic [COORD_W-1:0] pixel_y_q;
  logic               sof_q;
  logic               eol_q;

  // A fresh pair is needed only on even columns of even rows; every other pixel reuses one.
  assign need_c  = (phase_q == FILL) && !x_q[0];
  assign fire    = bus.y_valid && bus.y_ready;
  assign x_last  = (x_q == COORD_W'(IMG_WIDTH - 1));
  assign y_last  = (y_q == COORD_W'(IMG_HEIGHT - 1));
  assign lb_addr = LB_AW'(x_q >> 1);
  assign pair_in = {bus.u_in, bus.v_in};

  assign bus.y_ready = !need_c || bus.c_valid;
  assign bus.c_ready = need_c && bus.y_valid;

  always_comb begin
    chroma = lb_rdata;
    if (need_c) begin
      chroma = pair_in;
    end else if (phase_q == FILL) begin
      chroma = hold_q;
    end
  end

  yv12_chroma_linebuf #(
    .DEPTH (LB_DEPTH),
    .AW    (LB_AW)
  ) u_linebuf (
    .clk   (clk),
    .we    (need_c && fire && !rst),
    .waddr (lb_addr),
    .wdata (pair_in),
    .raddr (lb_addr),
    .rdata (lb_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q          <= '0;
      y_q          <= '0;
      phase_q      <= FILL;
      hold_q       <= '0;
      data_valid_q <= 1'b0;
      y_data_q     <= '0;
      u_data_q     <= '0;
      v_data_q     <= '0;
      pixel_x_q    <= '0;
      pixel_y_q    <= '0;
      sof_q        <= 1'b0;
      eol_q        <= 1'b0;
    end else begin
      data_valid_q <= fire;
      if (fire) begin
        y_data_q  <= bus.y_in;
        u_data_q  <= chroma[15:8];
        v_data_q  <= chroma[7:0];
        pixel_x_q <= x_q;
        pixel_y_q <= y_q;
        sof_q     <= (x_q == '0) && (y_q == '0);
        eol_q     <= x_last;
        if (need_c) begin
          hold_q <= pair_in;
        end
        if (x_last) begin
          x_q <= '0;
          if (y_last) begin
            y_q     <= '0;
            phase_q <= FILL;
          end else begin
            y_q     <= y_q + COORD_W'(1);
            phase_q <= (phase_q == FILL) ? REPLAY : FILL;
          end
        end else begin
          x_q <= x_q + COORD_W'(1);
        end
      end
    end
  end

  assign bus.data_valid = data_valid_q;
  assign bus.y_data     = y_data_q;
  assign bus.u_data     = u_data_q;
  assign bus.v_data     = v_data_q;
  assign bus.pixel_x    = pixel_x_q;
  assign bus.pixel_y    = pixel_y_q;
  assign bus.sof        = sof_q;
  assign bus.eol        = eol_q;

endmodule

// File: tb/tb_yv12_chroma_upsampler.sv
// tb/tb_yv12_chroma_upsampler.sv - randomized self-checking bench with pixel-coordinate chroma model
module tb_yv12_chroma_upsampler;

  localparam int W     = 32;
  localparam int H     = 6;
  localparam int CW    = 10;
  localparam int PAIRS = (W / 2) * (H / 2);

  logic clk;
  logic rst;

  yv12_chroma_upsampler_if #(.COORD_W(CW)) bus ();

  yv12_chroma_upsampler #(
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H),
    .COORD_W    (CW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors = 0;
  int checks = 0;

  // Model: pixel (x,y) carries the chroma pair with index (y/2)*(W/2) + x/2 of its frame.
  int          mx, my, m_acc;
  logic [15:0] pairs [PAIRS];
  logic        exp_dv, exp_sof, exp_eol;
  logic [7:0]  exp_y, exp_u, exp_v;
  int          exp_px, exp_py;
  int          n_c, n_sof, n_eol;
  logic [7:0]  cur_y, cur_u, cur_v;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input bit yv, input bit cv, input bit rs);
    bit need, fire;
    int idx;
    rst         = rs;
    bus.y_valid = yv;
    bus.c_valid = cv;
    bus.y_in    = cur_y;
    bus.u_in    = cur_u;
    bus.v_in    = cur_v;
    #1;
    need = (my % 2 == 0) && (mx % 2 == 0);
    fire = !rs && yv && (!need || cv);
    if (!rs) begin
      chk("y_ready", 32'(bus.y_ready), 32'(!need || cv));
      chk("c_ready", 32'(bus.c_ready), 32'(need && yv));
      if (bus.c_valid && bus.c_ready) n_c++;
    end
    if (rs) begin
      mx = 0; my = 0;
      exp_dv = 0; exp_y = 0; exp_u = 0; exp_v = 0;
      exp_px = 0; exp_py = 0; exp_sof = 0; exp_eol = 0;
    end else if (fire) begin
      idx = (my / 2) * (W / 2) + mx / 2;
      if (need) pairs[idx] = {cur_u, cur_v};
      exp_dv  = 1;
      exp_y   = cur_y;
      exp_u   = pairs[idx][15:8];
      exp_v   = pairs[idx][7:0];
      exp_px  = mx;
      exp_py  = my;
      exp_sof = (mx == 0) && (my == 0);
      exp_eol = (mx == W - 1);
      m_acc++;
      mx++;
      if (mx == W) begin
        mx = 0;
        my = (my + 1) % H;
      end
    end else begin
      exp_dv = 0;
    end
    @(posedge clk);
    #1;
    chk("data_valid", 32'(bus.data_valid), 32'(exp_dv));
    chk("y_data", 32'(bus.y_data), 32'(exp_y));
    chk("u_data", 32'(bus.u_data), 32'(exp_u));
    chk("v_data", 32'(bus.v_data), 32'(exp_v));
    chk("pixel_x", 32'(bus.pixel_x), 32'(exp_px));
    chk("pixel_y", 32'(bus.pixel_y), 32'(exp_py));
    chk("sof", 32'(bus.sof), 32'(exp_sof));
    chk("eol", 32'(bus.eol), 32'(exp_eol));
    if (bus.data_valid && bus.sof) n_sof++;
    if (bus.data_valid && bus.eol) n_eol++;
  endtask

  task automatic set_data(input int mode);
    int idx;
    if (mode == 0) begin
      idx   = (my / 2) * (W / 2) + mx / 2;
      cur_y = 8'(mx);
      cur_u = 8'(idx);
      cur_v = 8'(200 - idx);
    end else begin
      cur_y = 8'($urandom);
      cur_u = 8'($urandom);
      cur_v = 8'($urandom);
    end
  endtask

  // mode 0: both valid, ramp data; 1: both random; 2: c_valid held high, y_valid random
  task automatic run_pixels(input int n, input int mode, input int sx, input int sy);
    int  start;
    int  guard;
    bit  stalled;
    bit  yv, cv;
    start   = m_acc;
    guard   = 0;
    stalled = 0;
    while ((m_acc - start) < n && guard < n * 8 + 100) begin
      if (!stalled && mx == sx && my == sy) begin
        for (int i = 0; i < 5; i++) begin
          set_data(1);
          cycle(1'b1, 1'b0, 1'b0);
        end
        stalled = 1;
      end
      set_data(mode);
      case (mode)
        0:       begin yv = 1; cv = 1; end
        1:       begin yv = ($urandom_range(0, 3) != 0); cv = ($urandom_range(0, 3) != 0); end
        default: begin yv = 1'($urandom_range(0, 1)); cv = 1; end
      endcase
      cycle(yv, cv, 1'b0);
      guard++;
    end
    chk("run_len", 32'(m_acc - start), 32'(n));
  endtask

  initial begin
    mx = 0; my = 0; m_acc = 0;
    n_c = 0; n_sof = 0; n_eol = 0;
    cur_y = 0; cur_u = 0; cur_v = 0;
    rst = 1'b1;
    bus.y_valid = 1'b0;
    bus.c_valid = 1'b0;
    bus.y_in = '0;
    bus.u_in = '0;
    bus.v_in = '0;

    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);

    n_c = 0;
    run_pixels(W * H, 0, -1, -1);
    chk("pairs_frame_ramp", 32'(n_c), 32'(PAIRS));

    n_c = 0;
    run_pixels(W * H, 2, 10, 2);
    chk("pairs_frame_stall", 32'(n_c), 32'(PAIRS));

    n_c = 0; n_sof = 0; n_eol = 0;
    run_pixels(2 * W * H, 1, -1, -1);
    chk("pairs_two_frames", 32'(n_c), 32'(2 * PAIRS));
    chk("sof_count", 32'(n_sof), 32'd2);
    chk("eol_count", 32'(n_eol), 32'(2 * H));

    run_pixels(3 * W + 17, 1, -1, -1);
    set_data(1);
    cycle(1'b1, 1'b1, 1'b1);
    n_sof = 0;
    run_pixels(2 * W, 0, -1, -1);
    chk("sof_after_reset", 32'(n_sof), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
